store_buffer: RTL and testbench

// - In-order store buffer between the LSU execute stage and the data bus.
// - Accepts stores from the LSU execute stage, holds them speculatively until the commit

---
 rtl/store_buffer.sv | 225 ++++++++++++++++++++++
 tb/tb_store_buffer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order store buffer between the LSU execute stage and the data bus.
// Stores are held speculatively until retired by commit, then drained to the bus one
// at a time. Loads go to the bus read port unless they overlap a buffered store.
// Flush discards speculative (uncommitted) stores only.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   exlsu_stbuf_*                  store enqueue (push/rob_id/addr/size/data) and load request
//   stbuf_exlsu_full               buffer holds DEPTH entries
//   stbuf_exlsu_bus_*              load result: raw bus data, low-aligned feedback, ready
//   commit_stbuf_*                 retire strobe + ROB id, pipeline flush
//   stbuf_bus_read_*               load address/size passed straight to the bus
//   bus_stbuf_read_*               bus read data / ready
//   stbuf_bus_write_*              drain request and head entry fields
//   bus_stbuf_write_ack            drain accepted
//
// Build options:
//   STBUF_FORWARD_EN   forward data from the youngest overlapping store when it fully
//                      covers the load; otherwise any overlap stalls the load.
//   ADDR_WIDTH, BUS_DATA_WIDTH, SIZE_WIDTH, ROB_ID_WIDTH default below if not supplied.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 6
`endif

module store_buffer #(
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int ADDR_W    = `ADDR_WIDTH,
    parameter int DATA_W    = `BUS_DATA_WIDTH,
    parameter int SIZE_W    = `SIZE_WIDTH,
    parameter int ROB_W     = `ROB_ID_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exlsu_stbuf_push,
    input  logic [ROB_W-1:0]  exlsu_stbuf_rob_id,
    input  logic [ADDR_W-1:0] exlsu_stbuf_write_addr,
    input  logic [SIZE_W-1:0] exlsu_stbuf_write_size,
    input  logic [DATA_W-1:0] exlsu_stbuf_write_data,
    output logic              stbuf_exlsu_full,
    input  logic              exlsu_stbuf_read_req,
    input  logic [ADDR_W-1:0] exlsu_stbuf_read_addr,
    input  logic [SIZE_W-1:0] exlsu_stbuf_read_size,
    output logic [DATA_W-1:0] stbuf_exlsu_bus_data,
    output logic [DATA_W-1:0] stbuf_exlsu_bus_data_feedback,
    output logic              stbuf_exlsu_bus_ready,
    input  logic              commit_stbuf_retire,
    input  logic [ROB_W-1:0]  commit_stbuf_rob_id,
    input  logic              commit_stbuf_flush,
    output logic [ADDR_W-1:0] stbuf_bus_read_addr,
    output logic [SIZE_W-1:0] stbuf_bus_read_size,
    input  logic [DATA_W-1:0] bus_stbuf_read_data,
    input  logic              bus_stbuf_read_ready,
    output logic              stbuf_bus_write_req,
    output logic [ADDR_W-1:0] stbuf_bus_write_addr,
    output logic [SIZE_W-1:0] stbuf_bus_write_size,
    output logic [DATA_W-1:0] stbuf_bus_write_data,
    input  logic              bus_stbuf_write_ack
);

    localparam int CNT_W = PTR_WIDTH + 1;
    localparam int AX_W  = ADDR_W + 1;   // one spare bit so addr+size cannot wrap
`ifdef STBUF_FORWARD_EN
    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);
`endif

    typedef enum logic {IDLE, WRITE} state_t;

    logic [ROB_W-1:0]  mem_rob  [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [SIZE_W-1:0] mem_size [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [CNT_W-1:0]     head, commit_ptr, tail, count, commit_nxt;
    logic [PTR_WIDTH-1:0] head_idx, tail_idx;
    logic                 do_push, do_pop;
    state_t               state, state_nxt;

    assign count            = tail - head;
    assign stbuf_exlsu_full = (count == CNT_W'(DEPTH));
    assign head_idx         = head[PTR_WIDTH-1:0];
    assign tail_idx         = tail[PTR_WIDTH-1:0];
    assign do_push          = exlsu_stbuf_push && !stbuf_exlsu_full && !commit_stbuf_flush;
    assign do_pop           = (state == WRITE) && bus_stbuf_write_ack;
    assign commit_nxt       = commit_ptr + CNT_W'(commit_stbuf_retire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            commit_ptr <= '0;
            tail       <= '0;
        end else begin
            head       <= head + CNT_W'(do_pop);
            commit_ptr <= commit_nxt;
            // flush rolls tail back to the commit point including a same-cycle retire
            if (commit_stbuf_flush)
                tail <= commit_nxt;
            else if (do_push)
                tail <= tail + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_rob[tail_idx]  <= exlsu_stbuf_rob_id;
            mem_addr[tail_idx] <= exlsu_stbuf_write_addr;
            mem_size[tail_idx] <= exlsu_stbuf_write_size;
            mem_data[tail_idx] <= exlsu_stbuf_write_data;
        end
    end

    // drain FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (head != commit_ptr) state_nxt = WRITE;
            WRITE:   if (bus_stbuf_write_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stbuf_bus_write_req  = 1'b0;
        stbuf_bus_write_addr = '0;
        stbuf_bus_write_size = '0;
        stbuf_bus_write_data = '0;
        if (state == WRITE) begin
            stbuf_bus_write_req  = 1'b1;
            stbuf_bus_write_addr = mem_addr[head_idx];
            stbuf_bus_write_size = mem_size[head_idx];
            stbuf_bus_write_data = mem_data[head_idx];
        end
    end

    // loads
    assign stbuf_bus_read_addr  = exlsu_stbuf_read_addr;
    assign stbuf_bus_read_size  = exlsu_stbuf_read_size;
    assign stbuf_exlsu_bus_data = bus_stbuf_read_data;

    logic                 hit_any;
    logic [AX_W-1:0]      l_lo, l_hi;
`ifdef STBUF_FORWARD_EN
    logic [PTR_WIDTH-1:0] hit_idx;
    logic [AX_W-1:0]      h_lo, h_hi;
    logic [OFS_W-1:0]     ofs;
    logic [DATA_W-1:0]    mask;
    logic                 covers;
`endif

    // scan oldest to youngest so the last hit is the youngest overlapping store
    always_comb begin
        logic [PTR_WIDTH-1:0] idx;
        logic [AX_W-1:0]      e_lo, e_hi;
        hit_any = 1'b0;
        idx     = '0;
        e_lo    = '0;
        e_hi    = '0;
`ifdef STBUF_FORWARD_EN
        hit_idx = '0;
`endif
        l_lo = {1'b0, exlsu_stbuf_read_addr};
        l_hi = l_lo + AX_W'(exlsu_stbuf_read_size);
        for (int i = 0; i < DEPTH; i++) begin
            idx  = head_idx + PTR_WIDTH'(i);
            e_lo = {1'b0, mem_addr[idx]};
            e_hi = e_lo + AX_W'(mem_size[idx]);
            if (CNT_W'(i) < count && e_lo < l_hi && l_lo < e_hi) begin
                hit_any = 1'b1;
`ifdef STBUF_FORWARD_EN
                hit_idx = idx;
`endif
            end
        end
    end

`ifdef STBUF_FORWARD_EN
    always_comb begin
        h_lo   = {1'b0, mem_addr[hit_idx]};
        h_hi   = h_lo + AX_W'(mem_size[hit_idx]);
        covers = (h_lo <= l_lo) && (l_hi <= h_hi);
        ofs    = exlsu_stbuf_read_addr[OFS_W-1:0] - mem_addr[hit_idx][OFS_W-1:0];
        mask   = '0;
        for (int b = 0; b < BYTES; b++)
            if (b < int'(exlsu_stbuf_read_size)) mask[8*b +: 8] = 8'hFF;
        if (hit_any) begin
            stbuf_exlsu_bus_ready         = exlsu_stbuf_read_req && covers;
            stbuf_exlsu_bus_data_feedback = (mem_data[hit_idx] >> {ofs, 3'b000}) & mask;
        end else begin
            stbuf_exlsu_bus_ready         = exlsu_stbuf_read_req && bus_stbuf_read_ready;
            stbuf_exlsu_bus_data_feedback = bus_stbuf_read_data;
        end
    end
`else
    assign stbuf_exlsu_bus_ready         = exlsu_stbuf_read_req && bus_stbuf_read_ready && !hit_any;
    assign stbuf_exlsu_bus_data_feedback = bus_stbuf_read_data;
`endif

    a_push_full: assert property (@(posedge clk) disable iff (rst)
        !(exlsu_stbuf_push && stbuf_exlsu_full && !commit_stbuf_flush))
        else $warning("store_buffer: push while full dropped");

    a_retire: assert property (@(posedge clk) disable iff (rst)
        commit_stbuf_retire |-> (commit_ptr != tail) &&
                                (mem_rob[commit_ptr[PTR_WIDTH-1:0]] == commit_stbuf_rob_id))
        else $error("store_buffer: retire with no speculative entry or rob id mismatch");

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        exlsu_stbuf_push;
    logic [5:0]  exlsu_stbuf_rob_id;
    logic [31:0] exlsu_stbuf_write_addr;
    logic [2:0]  exlsu_stbuf_write_size;
    logic [31:0] exlsu_stbuf_write_data;
    logic        stbuf_exlsu_full;
    logic        exlsu_stbuf_read_req;
    logic [31:0] exlsu_stbuf_read_addr;
    logic [2:0]  exlsu_stbuf_read_size;
    logic [31:0] stbuf_exlsu_bus_data;
    logic [31:0] stbuf_exlsu_bus_data_feedback;
    logic        stbuf_exlsu_bus_ready;
    logic        commit_stbuf_retire;
    logic [5:0]  commit_stbuf_rob_id;
    logic        commit_stbuf_flush;
    logic [31:0] stbuf_bus_read_addr;
    logic [2:0]  stbuf_bus_read_size;
    logic [31:0] bus_stbuf_read_data;
    logic        bus_stbuf_read_ready;
    logic        stbuf_bus_write_req;
    logic [31:0] stbuf_bus_write_addr;
    logic [2:0]  stbuf_bus_write_size;
    logic [31:0] stbuf_bus_write_data;
    logic        bus_stbuf_write_ack;

    store_buffer dut (
        .clk                           (clk),
        .rst                           (rst),
        .exlsu_stbuf_push              (exlsu_stbuf_push),
        .exlsu_stbuf_rob_id            (exlsu_stbuf_rob_id),
        .exlsu_stbuf_write_addr        (exlsu_stbuf_write_addr),
        .exlsu_stbuf_write_size        (exlsu_stbuf_write_size),
        .exlsu_stbuf_write_data        (exlsu_stbuf_write_data),
        .stbuf_exlsu_full              (stbuf_exlsu_full),
        .exlsu_stbuf_read_req          (exlsu_stbuf_read_req),
        .exlsu_stbuf_read_addr         (exlsu_stbuf_read_addr),
        .exlsu_stbuf_read_size         (exlsu_stbuf_read_size),
        .stbuf_exlsu_bus_data          (stbuf_exlsu_bus_data),
        .stbuf_exlsu_bus_data_feedback (stbuf_exlsu_bus_data_feedback),
        .stbuf_exlsu_bus_ready         (stbuf_exlsu_bus_ready),
        .commit_stbuf_retire           (commit_stbuf_retire),
        .commit_stbuf_rob_id           (commit_stbuf_rob_id),
        .commit_stbuf_flush            (commit_stbuf_flush),
        .stbuf_bus_read_addr           (stbuf_bus_read_addr),
        .stbuf_bus_read_size           (stbuf_bus_read_size),
        .bus_stbuf_read_data           (bus_stbuf_read_data),
        .bus_stbuf_read_ready          (bus_stbuf_read_ready),
        .stbuf_bus_write_req           (stbuf_bus_write_req),
        .stbuf_bus_write_addr          (stbuf_bus_write_addr),
        .stbuf_bus_write_size          (stbuf_bus_write_size),
        .stbuf_bus_write_data          (stbuf_bus_write_data),
        .bus_stbuf_write_ack           (bus_stbuf_write_ack)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [5:0]  rob;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];      // reference contents, oldest first
    int   ncom;      // how many of q (from the front) are committed

    typedef struct {
        bit          req;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] bdata;
        bit          brdy;
        bit          exp_ready;
        logic [31:0] exp_fb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        exlsu_stbuf_push       = 0;
        exlsu_stbuf_rob_id     = 0;
        exlsu_stbuf_write_addr = 0;
        exlsu_stbuf_write_size = 0;
        exlsu_stbuf_write_data = 0;
        exlsu_stbuf_read_req   = 0;
        exlsu_stbuf_read_addr  = 0;
        exlsu_stbuf_read_size  = 0;
        commit_stbuf_retire    = 0;
        commit_stbuf_rob_id    = 0;
        commit_stbuf_flush     = 0;
        bus_stbuf_read_data    = 0;
        bus_stbuf_read_ready   = 0;
        bus_stbuf_write_ack    = 0;
    endtask

    task automatic push(input logic [5:0] rob, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] d);
        exlsu_stbuf_push       = 1;
        exlsu_stbuf_rob_id     = rob;
        exlsu_stbuf_write_addr = a;
        exlsu_stbuf_write_size = s;
        exlsu_stbuf_write_data = d;
        cyc();
        exlsu_stbuf_push = 0;
    endtask

    task automatic retire(input logic [5:0] rob);
        commit_stbuf_retire = 1;
        commit_stbuf_rob_id = rob;
        cyc();
        commit_stbuf_retire = 0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!stbuf_bus_write_req && n < 10) begin
            cyc();
            n++;
        end
        chk(nm, 32'(stbuf_bus_write_req), 32'd1);
    endtask

    // Reference load behaviour computed from byte ranges over the model queue.
    function automatic void load_model(input bit req, input logic [31:0] a, input logic [2:0] s,
                                       input logic [31:0] bd, input bit brdy,
                                       output bit er, output logic [31:0] efb);
        int     y = -1;
        longint la = longint'(a);
        longint ls = longint'(s);
        for (int k = 0; k < q.size(); k++) begin
            longint ea = longint'(q[k].addr);
            longint es = longint'(q[k].size);
            if (ea < la + ls && la < ea + es) y = k;
        end
        er  = req && brdy && (y < 0);
        efb = bd;
`ifdef STBUF_FORWARD_EN
        if (y >= 0) begin
            longint ea = longint'(q[y].addr);
            longint es = longint'(q[y].size);
            longint msk = (64'd1 << (8 * ls)) - 1;
            if (ea <= la && la + ls <= ea + es) begin
                er  = req;
                efb = 32'((longint'(q[y].data) >> (8 * (la - ea))) & msk);
            end else begin
                er = 0;
            end
        end
`endif
    endfunction

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1, 32'h300, 3'd4, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF};
        vecs[1] = '{1, 32'h300, 3'd4, 32'h12345678, 0, 0, 32'h0};
        vecs[2] = '{0, 32'h304, 3'd2, 32'h0000CAFE, 1, 0, 32'h0};
        vecs[3] = '{1, 32'h010, 3'd1, 32'h000000A5, 1, 1, 32'h000000A5};
        vecs[4] = '{1, 32'hFFFFFFFC, 3'd4, 32'h87654321, 1, 1, 32'h87654321};

        rst = 1;
        clr_in();
        #2;
        chk("rst_full", 32'(stbuf_exlsu_full), 0);
        chk("rst_write_req", 32'(stbuf_bus_write_req), 0);
        chk("rst_write_addr", stbuf_bus_write_addr, 0);
        chk("rst_ready", 32'(stbuf_exlsu_bus_ready), 0);
        chk("rst_feedback", stbuf_exlsu_bus_data_feedback, 0);
        cyc();
        cyc();
        rst = 0;
        cyc();

        // loads with an empty buffer
        for (int i = 0; i < 5; i++) begin
            exlsu_stbuf_read_req  = vecs[i].req;
            exlsu_stbuf_read_addr = vecs[i].addr;
            exlsu_stbuf_read_size = vecs[i].size;
            bus_stbuf_read_data   = vecs[i].bdata;
            bus_stbuf_read_ready  = vecs[i].brdy;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(stbuf_exlsu_bus_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_bus_data", i), stbuf_exlsu_bus_data, vecs[i].bdata);
            chk($sformatf("vec%0d_rd_addr", i), stbuf_bus_read_addr, vecs[i].addr);
            if (vecs[i].exp_ready)
                chk($sformatf("vec%0d_feedback", i), stbuf_exlsu_bus_data_feedback, vecs[i].exp_fb);
            cyc();
        end
        clr_in();

        // single store: push, retire, drain
        push(6'd3, 32'h100, 3'd4, 32'h11223344);
        retire(6'd3);
        chk("t2_req_not_yet", 32'(stbuf_bus_write_req), 0);
        cyc();
        chk("t2_req", 32'(stbuf_bus_write_req), 1);
        chk("t2_addr", stbuf_bus_write_addr, 32'h100);
        chk("t2_size", 32'(stbuf_bus_write_size), 4);
        chk("t2_data", stbuf_bus_write_data, 32'h11223344);
        cyc();
        chk("t2_req_held", 32'(stbuf_bus_write_req), 1);
        bus_stbuf_write_ack = 1;
        cyc();
        bus_stbuf_write_ack = 0;
        chk("t2_req_after_ack", 32'(stbuf_bus_write_req), 0);
        cyc();
        cyc();
        chk("t2_empty_no_req", 32'(stbuf_bus_write_req), 0);

        // fill to full
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_not_full_%0d", i), 32'(stbuf_exlsu_full), 0);
            push(6'(i), 32'h400 + 32'(4 * i), 3'd4, 32'(i));
        end
        chk("t3_full", 32'(stbuf_exlsu_full), 1);
        push(6'd60, 32'h480, 3'd4, 32'h5A5A5A5A);
        chk("t3_full_after_17th", 32'(stbuf_exlsu_full), 1);
        retire(6'd0);
        wait_req("t3_req");
        chk("t3_drain_addr", stbuf_bus_write_addr, 32'h400);
        chk("t3_full_before_pop", 32'(stbuf_exlsu_full), 1);
        bus_stbuf_write_ack = 1;
        cyc();
        bus_stbuf_write_ack = 0;
        chk("t3_full_after_pop", 32'(stbuf_exlsu_full), 0);
        commit_stbuf_flush = 1;
        cyc();
        commit_stbuf_flush = 0;
        cyc();
        cyc();
        chk("t3_flushed_no_req", 32'(stbuf_bus_write_req), 0);

        // flush in the same cycle as a retire
        begin
            logic [31:0] got[$];
            push(6'd1, 32'h500, 3'd4, 32'h1);
            push(6'd2, 32'h504, 3'd4, 32'h2);
            push(6'd3, 32'h508, 3'd4, 32'h3);
            retire(6'd1);
            commit_stbuf_flush = 1;
            retire(6'd2);
            commit_stbuf_flush = 0;
            for (int c = 0; c < 20; c++) begin
                if (stbuf_bus_write_req) begin
                    got.push_back(stbuf_bus_write_addr);
                    bus_stbuf_write_ack = 1;
                    cyc();
                    bus_stbuf_write_ack = 0;
                end else begin
                    cyc();
                end
            end
            chk("t4_drain_count", 32'(got.size()), 2);
            if (got.size() >= 2) begin
                chk("t4_first", got[0], 32'h500);
                chk("t4_second", got[1], 32'h504);
            end
        end

        // load hazard / forwarding against one pending store
        push(6'd7, 32'h200, 3'd4, 32'hAABBCCDD);
        exlsu_stbuf_read_req  = 1;
        exlsu_stbuf_read_addr = 32'h201;
        exlsu_stbuf_read_size = 3'd1;
        bus_stbuf_read_data   = 32'h55;
        bus_stbuf_read_ready  = 1;
        #1;
`ifdef STBUF_FORWARD_EN
        chk("t5_fwd_lbu_ready", 32'(stbuf_exlsu_bus_ready), 1);
        chk("t5_fwd_lbu_data", stbuf_exlsu_bus_data_feedback, 32'hCC);
        exlsu_stbuf_read_addr = 32'h1FE;
        exlsu_stbuf_read_size = 3'd4;
        #1;
        chk("t5_partial_ready", 32'(stbuf_exlsu_bus_ready), 0);
`else
        chk("t5_hazard_ready", 32'(stbuf_exlsu_bus_ready), 0);
`endif
        retire(6'd7);
        wait_req("t5_req");
        chk("t5_ready_during_write", 32'(stbuf_exlsu_bus_ready), 0);
        bus_stbuf_write_ack = 1;
        cyc();
        bus_stbuf_write_ack = 0;
        chk("t5_ready_after_drain", 32'(stbuf_exlsu_bus_ready), 1);
        chk("t5_fb_after_drain", stbuf_exlsu_bus_data_feedback, 32'h55);
        exlsu_stbuf_read_addr = 32'h300;
        exlsu_stbuf_read_size = 3'd4;
        bus_stbuf_read_data   = 32'h9ABCDEF0;
        #1;
        chk("t5_lw300_ready", 32'(stbuf_exlsu_bus_ready), 1);
        chk("t5_lw300_fb", stbuf_exlsu_bus_data_feedback, 32'h9ABCDEF0);
        clr_in();
        cyc();

        // async reset in the middle of a drain
        for (int i = 0; i < 5; i++) push(6'(10 + i), 32'h600 + 32'(4 * i), 3'd4, 32'(i));
        for (int i = 0; i < 5; i++) retire(6'(10 + i));
        wait_req("t6_req");
        #2;
        rst = 1;
        #1;
        chk("t6_rst_req", 32'(stbuf_bus_write_req), 0);
        chk("t6_rst_full", 32'(stbuf_exlsu_full), 0);
        chk("t6_rst_addr", stbuf_bus_write_addr, 0);
        chk("t6_rst_data", stbuf_bus_write_data, 0);
        cyc();
        rst = 0;
        cyc();
        cyc();
        cyc();
        chk("t6_empty_after_rst", 32'(stbuf_bus_write_req), 0);

        // randomized traffic against the queue model
        q.delete();
        ncom = 0;
        begin
            int idle_run = 0;
            for (int c = 0; c < 3000; c++) begin
                bit          p, r, f, a, lreq, brdy, er, req_seen;
                logic [2:0]  sz, lsz;
                logic [31:0] ad, lad, bd, efb;
                logic [5:0]  rob;
                p   = (q.size() < 16) && ($urandom_range(0, 2) != 0);
                r   = (ncom < q.size()) && ($urandom_range(0, 1) == 1);
                f   = ($urandom_range(0, 19) == 0);
                a   = ($urandom_range(0, 2) != 0);
                sz  = 3'(1 << $urandom_range(0, 2));
                ad  = 32'h100 + (32'($urandom_range(0, 31)) & ~(32'(sz) - 1));
                rob = 6'($urandom);
                lsz = 3'(1 << $urandom_range(0, 2));
                lad = 32'h100 + (32'($urandom_range(0, 31)) & ~(32'(lsz) - 1));
                lreq = ($urandom_range(0, 3) != 0);
                brdy = $urandom_range(0, 1) == 1;
                bd   = $urandom;
                exlsu_stbuf_push       = p;
                exlsu_stbuf_rob_id     = rob;
                exlsu_stbuf_write_addr = ad;
                exlsu_stbuf_write_size = sz;
                exlsu_stbuf_write_data = $urandom;
                commit_stbuf_retire    = r;
                commit_stbuf_rob_id    = r ? q[ncom].rob : 6'd0;
                commit_stbuf_flush     = f;
                bus_stbuf_write_ack    = a;
                exlsu_stbuf_read_req   = lreq;
                exlsu_stbuf_read_addr  = lad;
                exlsu_stbuf_read_size  = lsz;
                bus_stbuf_read_data    = bd;
                bus_stbuf_read_ready   = brdy;
                #1;
                chk("rnd_full", 32'(stbuf_exlsu_full), 32'(q.size() == 16));
                req_seen = stbuf_bus_write_req;
                if (req_seen) begin
                    chk("rnd_drain_committed", 32'(ncom > 0), 1);
                    if (q.size() > 0) begin
                        chk("rnd_drain_addr", stbuf_bus_write_addr, q[0].addr);
                        chk("rnd_drain_size", 32'(stbuf_bus_write_size), 32'(q[0].size));
                        chk("rnd_drain_data", stbuf_bus_write_data, q[0].data);
                    end
                end
                idle_run = (ncom > 0 && !req_seen) ? idle_run + 1 : 0;
                chk("rnd_drain_stall", 32'(idle_run > 2), 0);
                load_model(lreq, lad, lsz, bd, brdy, er, efb);
                chk("rnd_ready", 32'(stbuf_exlsu_bus_ready), 32'(er));
                chk("rnd_bus_data", stbuf_exlsu_bus_data, bd);
                if (er) chk("rnd_feedback", stbuf_exlsu_bus_data_feedback, efb);
                @(posedge clk);
                if (r) ncom++;
                if (f) begin
                    while (q.size() > ncom) q.delete(q.size() - 1);
                end else if (p) begin
                    q.push_back('{rob, ad, sz, exlsu_stbuf_write_data});
                end
                if (req_seen && a && q.size() > 0) begin
                    void'(q.pop_front());
                    ncom--;
                end
                #1;
            end
        end
        clr_in();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
